// File: rtl/simon_pkg.sv
// simon_pkg: shared state encodings, button codes and one-hot helpers for the Simon game.
package simon_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_RELEASE  = 2'd2
    } state_e;

    localparam logic [1:0] BTN_0 = 2'd0;
    localparam logic [1:0] BTN_1 = 2'd1;
    localparam logic [1:0] BTN_2 = 2'd2;
    localparam logic [1:0] BTN_3 = 2'd3;

    localparam int DB_TICKS_DEFAULT = 4;

    function automatic logic is_onehot4(input logic [3:0] b);
        return (b != 4'd0) && ((b & (b - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot4_to_code(input logic [3:0] b);
        return b[3] ? BTN_3 : b[2] ? BTN_2 : b[1] ? BTN_1 : BTN_0;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// btn_sync: two-flop synchronizer for asynchronous inputs, synchronous active-high reset.
module btn_sync #(
    parameter int W = 4
) (
    input  logic         clk_tick,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_tick) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/simon_btn_encoder.sv
// simon_btn_encoder: debounces four raw buttons into one encoded single-cycle press event.
// Chords from idle raise chord_err; all buttons must be released before the next press.
module simon_btn_encoder
    import simon_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEFAULT
) (
    input  logic       clk_tick,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    output logic       btn_valid,
    output logic [1:0] btn_val,
    output logic       chord_err,
    output logic [1:0] state,
    output logic [7:0] db_cnt
);
    localparam logic [7:0] DB = 8'(DB_TICKS);

    logic [3:0] btn_s;
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] cand_q, cand_d;
    logic [1:0] val_q, val_d;
    logic       valid_q, valid_d;
    logic       chord_q, chord_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    btn_sync #(.W(4)) u_sync (
        .clk_tick (clk_tick),
        .reset    (reset),
        .d_i      (btn_raw),
        .q_o      (btn_s)
    );

    always_ff @(posedge clk_tick) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            cand_q  <= 2'd0;
            val_q   <= 2'd0;
            valid_q <= 1'b0;
            chord_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            val_q   <= val_d;
            valid_q <= valid_d;
            chord_q <= chord_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        val_d   = val_q;
        valid_d = 1'b0;
        chord_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_onehot4(btn_s)) begin
                    cand_d  = onehot4_to_code(btn_s);
                    cnt_d   = 8'd1;
                    state_d = S_DEBOUNCE;
                end else if (btn_s != 4'd0) begin
                    chord_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_RELEASE;
                end
            end
            S_DEBOUNCE: begin
                // Any deviation from the candidate, including an added button, is a bounce.
                if (btn_s != (4'b0001 << cand_q)) begin
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end else if (cnt_q == DB) begin
                    valid_d = 1'b1;
                    val_d   = cand_q;
                    cnt_d   = 8'd0;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_RELEASE: begin
                if (btn_s != 4'd0) begin
                    cnt_d = 8'd0;
                end else if (sat_inc(cnt_q) == DB) begin
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign btn_valid = valid_q;
    assign btn_val   = val_q;
    assign chord_err = chord_q;
    assign state     = state_q;
    assign db_cnt    = cnt_q;
endmodule

// File: tb/tb_simon_btn_encoder.sv
// tb_simon_btn_encoder: directed checks of press latency, bounce rejection, chords and reset.
module tb_simon_btn_encoder;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic       btn_valid, chord_err;
    logic [1:0] btn_val, state;
    logic [7:0] db_cnt;
    logic       d1_valid, d1_chord;
    logic [1:0] d1_val, d1_state;
    logic [7:0] d1_cnt;
    int         passed = 0;
    int         total = 0;
    int         nvalid = 0;
    int         nchord = 0;
    int         v0, c0;

    always #5 clk = ~clk;

    simon_btn_encoder dut (
        .clk_tick  (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_valid (btn_valid),
        .btn_val   (btn_val),
        .chord_err (chord_err),
        .state     (state),
        .db_cnt    (db_cnt)
    );

    simon_btn_encoder #(.DB_TICKS(1)) dut1 (
        .clk_tick  (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_valid (d1_valid),
        .btn_val   (d1_val),
        .chord_err (d1_chord),
        .state     (d1_state),
        .db_cnt    (d1_cnt)
    );

    always @(posedge clk) begin
        if (btn_valid) nvalid <= nvalid + 1;
        if (chord_err) nchord <= nchord + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    initial begin
        reset = 1'b1;
        btn_raw = 4'd0;
        tick(3);
        check("rst_state", 32'(state), 32'd0);
        check("rst_cnt", 32'(db_cnt), 32'd0);
        check("rst_valid", 32'(btn_valid), 32'd0);
        check("rst_val", 32'(btn_val), 32'd0);
        check("rst_chord", 32'(chord_err), 32'd0);
        reset = 1'b0;
        tick(2);
        // clean press of button 2, held 20 cycles
        btn_raw = 4'b0100;
        tick(3);
        check("db1_pre", 32'(d1_valid), 32'd0);
        check("db1_state", 32'(d1_state), 32'd1);
        tick(1);
        check("db1_valid", 32'(d1_valid), 32'd1);
        check("db1_val", 32'(d1_val), 32'd2);
        tick(2);
        check("t1_deb_state", 32'(state), 32'd1);
        check("t1_deb_cnt", 32'(db_cnt), 32'd4);
        check("t1_early", 32'(btn_valid), 32'd0);
        tick(1);
        check("t1_valid", 32'(btn_valid), 32'd1);
        check("t1_val", 32'(btn_val), 32'd2);
        check("t1_chord", 32'(chord_err), 32'd0);
        tick(1);
        check("t1_one_cycle", 32'(btn_valid), 32'd0);
        check("t1_val_held", 32'(btn_val), 32'd2);
        check("t1_release_st", 32'(state), 32'd2);
        tick(12);
        btn_raw = 4'd0;
        tick(5);
        check("t1_rel_state", 32'(state), 32'd2);
        check("t1_rel_cnt", 32'(db_cnt), 32'd3);
        tick(1);
        check("t1_idle", 32'(state), 32'd0);
        check("t1_npulse", 32'(nvalid), 32'd1);
        check("t1_nchord", 32'(nchord), 32'd0);
        // button 1 bouncing, then stable
        v0 = nvalid;
        for (int i = 0; i < 3; i++) begin
            btn_raw = 4'b0010;
            tick(2);
            btn_raw = 4'd0;
            tick(2);
        end
        btn_raw = 4'b0010;
        tick(6);
        check("t2_no_bounce_pulse", 32'(nvalid), 32'(v0));
        check("t2_early", 32'(btn_valid), 32'd0);
        tick(1);
        check("t2_valid", 32'(btn_valid), 32'd1);
        check("t2_val", 32'(btn_val), 32'd1);
        tick(3);
        btn_raw = 4'd0;
        tick(6);
        check("t2_idle", 32'(state), 32'd0);
        check("t2_npulse", 32'(nvalid), 32'(v0 + 1));
        // button 3 long hold, extra button during release, release bounce
        v0 = nvalid;
        c0 = nchord;
        btn_raw = 4'b1000;
        tick(7);
        check("t3_valid", 32'(btn_valid), 32'd1);
        check("t3_val", 32'(btn_val), 32'd3);
        tick(20);
        btn_raw = 4'b1001;
        tick(20);
        btn_raw = 4'b1000;
        tick(153);
        for (int i = 0; i < 3; i++) begin
            btn_raw = 4'd0;
            tick(1);
            btn_raw = 4'b1000;
            tick(1);
        end
        btn_raw = 4'd0;
        tick(5);
        check("t3_rel_state", 32'(state), 32'd2);
        check("t3_rel_cnt", 32'(db_cnt), 32'd3);
        tick(1);
        check("t3_idle", 32'(state), 32'd0);
        check("t3_npulse", 32'(nvalid), 32'(v0 + 1));
        check("t3_nchord", 32'(nchord), 32'(c0));
        // second button added during debounce
        v0 = nvalid;
        btn_raw = 4'b0010;
        tick(3);
        check("t5_deb", 32'(state), 32'd1);
        btn_raw = 4'b0110;
        tick(2);
        check("t5_cnt3", 32'(db_cnt), 32'd3);
        tick(1);
        check("t5_bounce_idle", 32'(state), 32'd0);
        check("t5_bounce_cnt", 32'(db_cnt), 32'd0);
        tick(1);
        check("t5_chord", 32'(chord_err), 32'd1);
        check("t5_chord_state", 32'(state), 32'd2);
        btn_raw = 4'd0;
        tick(6);
        check("t5_idle", 32'(state), 32'd0);
        check("t5_npulse", 32'(nvalid), 32'(v0));
        // chord of buttons 0 and 3
        v0 = nvalid;
        c0 = nchord;
        btn_raw = 4'b1001;
        tick(2);
        check("t4_chord_early", 32'(chord_err), 32'd0);
        tick(1);
        check("t4_chord", 32'(chord_err), 32'd1);
        check("t4_no_valid", 32'(btn_valid), 32'd0);
        check("t4_val_kept", 32'(btn_val), 32'd3);
        check("t4_state", 32'(state), 32'd2);
        tick(1);
        check("t4_chord_once", 32'(chord_err), 32'd0);
        tick(6);
        btn_raw = 4'd0;
        tick(6);
        check("t4_idle", 32'(state), 32'd0);
        check("t4_nchord", 32'(nchord), 32'(c0 + 1));
        check("t4_npulse", 32'(nvalid), 32'(v0));
        btn_raw = 4'b0001;
        tick(7);
        check("t4_b0_valid", 32'(btn_valid), 32'd1);
        check("t4_b0_val", 32'(btn_val), 32'd0);
        tick(3);
        btn_raw = 4'd0;
        tick(6);
        btn_raw = 4'b0010;
        tick(7);
        check("t6_pre_val", 32'(btn_val), 32'd1);
        tick(3);
        btn_raw = 4'd0;
        tick(6);
        // reset during debounce
        v0 = nvalid;
        btn_raw = 4'b0100;
        tick(5);
        check("t6_deb", 32'(state), 32'd1);
        check("t6_cnt3", 32'(db_cnt), 32'd3);
        reset = 1'b1;
        tick(1);
        check("t6_state", 32'(state), 32'd0);
        check("t6_cnt", 32'(db_cnt), 32'd0);
        check("t6_valid", 32'(btn_valid), 32'd0);
        check("t6_val", 32'(btn_val), 32'd0);
        check("t6_chord", 32'(chord_err), 32'd0);
        tick(1);
        btn_raw = 4'd0;
        reset = 1'b0;
        tick(10);
        check("t6_no_pulse", 32'(nvalid), 32'(v0));
        check("t6_idle", 32'(state), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
